mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multicycle MIPS
//  processor between the CPU memory port and an external port (loader/DMA/debug).
//  Issues one transaction at a time to memory with fixed MEM_LAT-cycle access and
//  returns a one-cycle done pulse per requester. Stalls the CPU controller while
//  its access is pending.
// PARAMETERS
//  AW         32  address width
//  DW         32  data width
//  MEM_LAT    2   cycles mem_read/mem_write held per access; mem_rdata valid in last one (>=1)
//  STARVE_MAX 4   consecutive contested CPU wins before EXT is forced a grant (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  cpu_req    in   1   CPU access request, level, held until cpu_done
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  CPU read data, registered, valid with cpu_done
//  cpu_done   out  1   one-cycle completion pulse
//  cpu_stall  out  1   cpu_req & ~cpu_done (combinational)
//  ext_req/ext_we/ext_addr/ext_wdata/ext_rdata/ext_done: same as cpu_* for EXT port
//  mem_read   out  1   memory read strobe
//  mem_write  out  1   memory write strobe
//  mem_addr   out  AW  latched address of granted access
//  mem_wdata  out  DW  latched write data of granted access
//  mem_rdata  in   DW  memory read data
// BEHAVIOUR
//  - Reset (async): state IDLE; mem_read, mem_write, cpu_done, ext_done = 0;
//    mem_addr, mem_wdata, cpu_rdata, ext_rdata = 0; latency and starvation counters
//    = 0; last-grant = EXT (so CPU wins first contest). In-flight access abandoned,
//    no done pulse ever issued for it.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: reqs sampled; if any, pick grantee, latch its we/addr/wdata, go BUSY.
//    BUSY: MEM_LAT cycles; mem_read (we=0) or mem_write (we=1) high throughout,
//      mem_addr/mem_wdata stable. Last BUSY cycle: on read, capture mem_rdata into
//      grantee's rdata reg; on write, rdata regs unchanged.
//    DONE: grantee's done high exactly this cycle; strobes low; other port ignored.
//  - Timing: grant in cycle t -> strobes t+1..t+MEM_LAT -> done at t+MEM_LAT+1 ->
//    IDLE at t+MEM_LAT+2. Back-to-back access every MEM_LAT+2 cycles.
//  - Requester drops req (or changes addr) on the edge ending its done cycle; req
//    still high in IDLE is a new access. Input changes during BUSY/DONE are ignored.
//  - Non-granted req waits; its done stays 0; never lost.
//  - Arbitration (single requester always wins). Contested case, macro absent:
//    CPU wins unless starve_cnt == STARVE_MAX, then EXT wins and starve_cnt := 0;
//    each contested CPU win increments starve_cnt (saturating at STARVE_MAX);
//    uncontested grants leave starve_cnt unchanged; any EXT grant clears it.
//  - Latency counter width $clog2(MEM_LAT+1); no wrap beyond MEM_LAT.
//  - At most one of mem_read/mem_write, and of cpu_done/ext_done, high in any cycle.
// CONFIGURATION
//  ARB_RR_EN defined: contested case alternates strictly via last-grant bit
//    (winner = port not granted last); starvation counter not built.
//  ARB_RR_EN undefined: fixed CPU priority with STARVE_MAX fairness as above.
// TESTING
//  1 MEM_LAT=2, CPU-only read 0x10, mem_rdata=0xDEADBEEF -> grant t0, mem_read t1-t2
//    mem_addr=0x10, cpu_done t3 with cpu_rdata=0xDEADBEEF, cpu_stall t0..t2 high.
//  2 EXT-only write 0x20/0x55 -> mem_write 2 cycles, mem_addr=0x20, mem_wdata=0x55,
//    ext_done one pulse, ext_rdata unchanged.
//  3 No macro, STARVE_MAX=4, both reqs held high -> grant order CPU,CPU,CPU,CPU,EXT
//    repeating; no done overlap.
//  4 ARB_RR_EN, both reqs held high from reset -> CPU,EXT,CPU,EXT.
//  5 rst pulsed during 2nd BUSY cycle of read -> strobes 0 immediately, no done
//    pulse, rdata=0; after release held req granted fresh with full latency.
//  6 CPU req arrives during EXT BUSY -> CPU granted in IDLE after ext_done, cpu_stall
//    high throughout wait.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter that lets the multicycle MIPS CPU and an external loader/DMA share one memory.
// Define ARB_RR_EN for strict round-robin on contested requests; otherwise CPU priority with starvation bound.
module mips_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_done,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam logic [LW-1:0] LAT_MAX = LW'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [LW-1:0] lat_cnt;
    logic          gnt_ext;
    logic          pick_ext;
    logic          contested;
    logic          pick_we;

    assign contested = cpu_req & ext_req;
    assign cpu_stall = cpu_req & ~cpu_done;
    assign pick_we   = pick_ext ? ext_we : cpu_we;

`ifdef ARB_RR_EN
    logic last_ext;

    always_comb begin
        pick_ext = ext_req;
        if (contested) pick_ext = ~last_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_ext <= 1'b1;
        else if (state == IDLE && (cpu_req || ext_req))
            last_ext <= pick_ext;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    always_comb begin
        pick_ext = ext_req;
        if (contested) pick_ext = (starve_cnt == SMAX);
    end

    // Only contested CPU wins count toward forcing an EXT grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (state == IDLE && (cpu_req || ext_req)) begin
            if (pick_ext)
                starve_cnt <= '0;
            else if (contested && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            gnt_ext   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            cpu_done  <= 1'b0;
            ext_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || ext_req) begin
                        gnt_ext   <= pick_ext;
                        mem_addr  <= pick_ext ? ext_addr : cpu_addr;
                        mem_wdata <= pick_ext ? ext_wdata : cpu_wdata;
                        mem_read  <= ~pick_we;
                        mem_write <= pick_we;
                        lat_cnt   <= LW'(1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (lat_cnt == LAT_MAX) begin
                        if (mem_read) begin
                            if (gnt_ext) ext_rdata <= mem_rdata;
                            else         cpu_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cpu_done  <= ~gnt_ext;
                        ext_done  <= gnt_ext;
                        lat_cnt   <= '0;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    cpu_done <= 1'b0;
                    ext_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter (MEM_LAT=2, STARVE_MAX=4); memory model returns addr-derived data.
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_stall, ext_done, mem_read, mem_write;

    int n_cmp = 0;
    int n_err = 0;

    mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_done(ext_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 0x10 holds 0xDEADBEEF; every other word reads as addr ^ 0xA5A50000
    assign mem_rdata = !mem_read ? 32'h0 :
                       (mem_addr == 32'h10) ? 32'hDEADBEEF : (mem_addr ^ 32'hA5A50000);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic got_ext [10];
    int   n_dn;
    logic exp_ext;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        repeat (2) step();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_dones", {cpu_done, ext_done}, 0);
        chk("rst_rdata", {cpu_rdata, ext_rdata}, 0);
        rst = 1'b0;

        // CPU-only read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1 chk("t1_stall_t0", cpu_stall, 1);
        step();
        chk("t1_read_t1", mem_read, 1);
        chk("t1_addr_t1", mem_addr, 32'h10);
        chk("t1_stall_t1", cpu_stall, 1);
        step();
        chk("t1_read_t2", mem_read, 1);
        chk("t1_stall_t2", cpu_stall, 1);
        chk("t1_done_t2", cpu_done, 0);
        step();
        chk("t1_done_t3", cpu_done, 1);
        chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_read_t3", mem_read, 0);
        chk("t1_stall_t3", cpu_stall, 0);
        cpu_req = 0;
        step();
        chk("t1_done_t4", cpu_done, 0);

        // EXT-only write 0x20/0x55
        ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h55;
        step();
        chk("t2_strobes_t1", {mem_read, mem_write}, 2'b01);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_wdata", mem_wdata, 32'h55);
        step();
        chk("t2_strobes_t2", {mem_read, mem_write}, 2'b01);
        chk("t2_done_t2", ext_done, 0);
        step();
        chk("t2_dones_t3", {cpu_done, ext_done}, 2'b01);
        chk("t2_strobes_t3", {mem_read, mem_write}, 2'b00);
        chk("t2_ext_rdata", ext_rdata, 0);
        ext_req = 0; ext_we = 0;
        step();
        chk("t2_done_t4", ext_done, 0);

        // CPU request arrives while EXT read of 0x30 is busy
        ext_req = 1; ext_addr = 32'h30;
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        #1 chk("t6_stall_s1", cpu_stall, 1);
        step();
        chk("t6_stall_s2", cpu_stall, 1);
        chk("t6_addr_s2", mem_addr, 32'h30);
        step();
        chk("t6_dones_s3", {cpu_done, ext_done}, 2'b01);
        chk("t6_ext_rdata", ext_rdata, 32'hA5A50030);
        chk("t6_stall_s3", cpu_stall, 1);
        ext_req = 0;
        step();
        chk("t6_idle_s4", {mem_read, cpu_stall}, 2'b01);
        step();
        chk("t6_read_s5", mem_read, 1);
        chk("t6_addr_s5", mem_addr, 32'h40);
        step();
        chk("t6_done_s6", cpu_done, 0);
        step();
        chk("t6_done_s7", cpu_done, 1);
        chk("t6_cpu_rdata", cpu_rdata, 32'hA5A50040);
        cpu_req = 0;
        step();

        // Reset during second BUSY cycle of a CPU read; req kept high
        cpu_req = 1; cpu_addr = 32'h10;
        step();
        step();
        chk("t5_read_pre", mem_read, 1);
        rst = 1'b1;
        #1;
        chk("t5_read_rst", mem_read, 0);
        chk("t5_rdata_rst", cpu_rdata, 0);
        step();
        chk("t5_done_rst", {cpu_done, ext_done}, 0);
        rst = 1'b0;
        #1 chk("t5_u0", {mem_read, cpu_done, cpu_stall}, 3'b001);
        step();
        chk("t5_read_u1", mem_read, 1);
        step();
        chk("t5_u2", {mem_read, cpu_done}, 2'b10);
        step();
        chk("t5_done_u3", cpu_done, 1);
        chk("t5_rdata_u3", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        step();

        // Both ports held high from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_req = 1; cpu_addr = 32'h100;
        ext_req = 1; ext_we = 0; ext_addr = 32'h200;
        n_dn = 0;
        for (int c = 0; c < 80 && n_dn < 10; c++) begin
            step();
            chk("t3_done_excl", cpu_done & ext_done, 0);
            chk("t3_strobe_excl", mem_read & mem_write, 0);
            if (cpu_done || ext_done) begin
                got_ext[n_dn] = ext_done;
                n_dn++;
            end
        end
        chk("t3_grant_count", n_dn, 10);
        for (int i = 0; i < n_dn; i++) begin
`ifdef ARB_RR_EN
            exp_ext = (i % 2 == 1);
`else
            exp_ext = (i % 5 == 4);
`endif
            chk($sformatf("t3_order_%0d", i), got_ext[i], exp_ext);
        end
        cpu_req = 0; ext_req = 0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
